uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for 8N1 serial frames, the downstream counterpart of the UART transmitter. It samples the asynchronous `rx` line with a 16x oversampling tick from an internal baud divider, validates the start and stop bits, and presents each received byte with a one-cycle `rx_done` strobe. It connects directly to the transmitter's `tx` line for loopback, or to an external pin.

## Interface
- `CLK_DIV`, default 163: clock cycles per oversampling tick (50 MHz / (19200 × 16)); legal range ≥ 2.
- `DBIT`, default 8: data bits per frame.
- `SB_TICK`, default 16: oversampling ticks in the stop bit.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input, asynchronous to `clk`, idles high.
- `d_out` out 8: last correctly framed byte. Holds its value until the next good frame.
- `rx_done` out 1: one-cycle pulse when `d_out` updates.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1. All decisions use the synchronized `rx_s`.
- Tick divider:
  - Free-running counter 0..CLK_DIV-1.
  - `tick` is high for one cycle when the count equals CLK_DIV-1, then the counter wraps to 0.
  - `reset` clears it. Otherwise it is never cleared.
- FSM states: IDLE, START, DATA, STOP. Counters: `s` (4 bit, ticks), `n` (3 bit, bits), shift register `b` (8 bit).
- IDLE:
  - On `rx_s == 0`, go to START with `s = 0`.
  - This transition is evaluated every clock, not only on ticks.
- START, on each tick:
  - If `s == 7` (mid start bit): if `rx_s == 0`, go to DATA with `s = 0`, `n = 0`; else treat it as a glitch and return to IDLE. No outputs change on a glitch.
  - Otherwise `s++`.
- DATA, on each tick:
  - If `s == 15`: set `b = {rx_s, b[7:1]}` (LSB first) and `s = 0`.
  - If `n == DBIT-1`, go to STOP; else `n++`.
  - Otherwise `s++`.
- STOP, on each tick:
  - If `s == SB_TICK-1`:
    - If `rx_s == 1`: `d_out <= b` and pulse `rx_done`.
    - Else pulse `frame_err` and leave `d_out` unchanged.
    - Return to IDLE in either case.
  - Otherwise `s++`.
- Reset values: state IDLE; `s`, `n`, `b`, `d_out` = 0; `rx_done` = 0; `frame_err` = 0.
- Reset mid-frame aborts the frame with no output pulses. Reception resumes at the next falling edge after release.
- A line held low (break) produces one `frame_err`. IDLE then re-enters START immediately and repeats `frame_err` every frame time until the line returns high.

## Timing
- Input synchronizer latency: 2 clk.
- Start-bit detection resolution: 1 tick, plus the divider phase.
- Data sampling: nominally mid-bit, at 8 + 16·k ticks after the detected falling edge, for k = 1..DBIT.
- Stop bit is sampled at 8 + 16·(DBIT+1) ticks.
- `rx_done` / `frame_err` are registered and high for exactly one clk, the cycle after the stop-sampling tick.
- `d_out` is valid from the cycle `rx_done` is high.
- Back-to-back frames (stop bit followed immediately by the next start bit) are received without loss.
- Baud tolerance: ±3 % relative to the transmitter.

## Structure
- Shared package/header `uart_pkg`:
  - FSM state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - Default `CLK_DIV`, `DBIT`, `SB_TICK`, shared with the transmitter so both ends agree on baud.
- Sub-module `uart_baud_gen`: parameter `CLK_DIV`, ports `clk`, `reset`, `tick`. The transmitter reuses it with the same parameter.
- `uart_rx` contains the synchronizer, FSM, counters and output registers.

## Test plan
All scenarios use `CLK_DIV = 4`, giving 1 bit = 64 clk.
- Frame 0xF0 (start 0, bits LSB first 0,0,0,0,1,1,1,1, stop 1) → `d_out = 8'hF0`, `rx_done` high exactly 1 clk, `frame_err` never high.
- Back-to-back 0x55 then 0xAA, with no idle gap → two `rx_done` pulses, `d_out` 0x55 then 0xAA, pulses ≈ 640 clk apart.
- `rx` low for 3 ticks (12 clk) then high → no `rx_done` or `frame_err`; FSM back in IDLE; a following 0x3C frame is received correctly.
- Frame 0xA5 with stop bit driven 0, after a prior good 0x11 → `frame_err` pulses once, `rx_done` stays low, `d_out` stays 0x11.
- `reset` asserted during data bit 4 of a frame → immediately `d_out = 0`, no pulses. After release, frame 0x7E → `d_out = 0x7E`.
- Loopback from the transmitter's `tx` with matching `CLK_DIV`: send 0xF0, 0x55, 0xAA → received bytes match in order, with no `frame_err`.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmitter and receiver.
//               Holds the receiver FSM state encodings and the default baud
//               configuration, so both ends of a link agree on bit timing.
//               Defaults: 50 MHz clock, 19200 baud, 16x oversampling, 8N1.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // Default link configuration: 50e6 / (19200 * 16) ~= 163
    localparam int c_DEF_CLK_DIV = 163;
    localparam int c_DEF_DBIT    = 8;
    localparam int c_DEF_SB_TICK = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Free-running oversampling tick generator. Counts
//               0..CLK_DIV-1 and asserts tick for the single cycle in which
//               the count equals CLK_DIV-1, then wraps to 0. Only reset
//               clears the counter, so the tick phase is never disturbed by
//               traffic on the line.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-high reset
//               tick  - one-cycle oversampling strobe
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = c_DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign tick = w_wrap;

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 16x oversampling. The asynchronous
//               rx line is synchronized, the start bit is confirmed at its
//               midpoint, data bits are sampled mid-bit LSB first, and the
//               stop bit is checked before the byte is published.
// Ports       : clk       - system clock, rising edge
//               reset     - asynchronous, active-high reset
//               rx        - serial input, idles high, asynchronous to clk
//               d_out     - last correctly framed byte (held between frames)
//               rx_done   - one-cycle pulse when d_out updates
//               frame_err - one-cycle pulse when the stop bit samples low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = c_DEF_CLK_DIV,
    parameter int DBIT    = c_DEF_DBIT,
    parameter int SB_TICK = c_DEF_SB_TICK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] d_out,
    output logic       rx_done,
    output logic       frame_err
);

    localparam logic [3:0] c_S_MID   = 4'd7;
    localparam logic [3:0] c_S_LAST  = 4'd15;
    localparam logic [3:0] c_SB_LAST = 4'(SB_TICK - 1);
    localparam logic [2:0] c_N_LAST  = 3'(DBIT - 1);

    // ------------------------------------------------------------------
    // Synchronizer and oversampling tick
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;
    logic w_tick;

    // Both stages reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    logic [1:0] r_state, w_state_nxt;
    logic [3:0] r_s,     w_s_nxt;
    logic [2:0] r_n,     w_n_nxt;
    logic [7:0] r_b,     w_b_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        case (r_state)
            c_ST_IDLE: begin
                // Falling edge is checked every clock so detection
                // resolution is set by the tick, not by a tick boundary.
                if (!r_rx_s) begin
                    w_state_nxt = c_ST_START;
                    w_s_nxt     = '0;
                end
            end
            c_ST_START: begin
                if (w_tick) begin
                    if (r_s == c_S_MID) begin
                        // Still low at mid start bit: a real frame.
                        // High here means a glitch; drop it silently.
                        if (!r_rx_s) begin
                            w_state_nxt = c_ST_DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            c_ST_DATA: begin
                if (w_tick) begin
                    if (r_s == c_S_LAST) begin
                        w_s_nxt = '0;
                        w_b_nxt = {r_rx_s, r_b[7:1]};
                        if (r_n == c_N_LAST) begin
                            w_state_nxt = c_ST_STOP;
                        end else begin
                            w_n_nxt = r_n + 3'd1;
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            c_ST_STOP: begin
                if (w_tick) begin
                    if (r_s == c_SB_LAST) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    logic w_stop_sample;
    logic w_done_set;
    logic w_err_set;

    always_comb begin
        w_stop_sample = (r_state == c_ST_STOP) && w_tick && (r_s == c_SB_LAST);
        w_done_set    = w_stop_sample && r_rx_s;
        w_err_set     = w_stop_sample && !r_rx_s;
    end

    // Registered outputs: pulses land the cycle after the stop-sampling
    // tick, together with the new d_out value.
    logic [7:0] r_d_out;
    logic       r_rx_done;
    logic       r_frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_out     <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done   <= w_done_set;
            r_frame_err <= w_err_set;
            if (w_done_set) begin
                r_d_out <= r_b;
            end
        end
    end

    assign d_out     = r_d_out;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx with CLK_DIV = 4
//               (one bit = 64 clk). A behavioural serial driver plays the
//               role of the transmitter; a negedge monitor records pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int c_BIT = 64;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_DIV (4),
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .d_out     (d_out),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int         cyc       = 0;
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         wide_cnt  = 0;
    int         done_last = 0;
    int         done_prev = 0;
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt  <= done_cnt + 1;
            done_prev <= done_last;
            done_last <= cyc;
            rx_q.push_back(d_out);
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if ((rx_done && prev_done) || (frame_err && prev_err)) wide_cnt <= wide_cnt + 1;
        prev_done <= rx_done;
        prev_err  <= frame_err;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int ncyc);
        rx = v;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        hold(1'b0, c_BIT);
        for (int i = 0; i < 8; i++) hold(data[i], c_BIT);
        hold(stop_bit, c_BIT);
        rx = 1'b1;
    endtask

    task automatic settle(input int ncyc);
        rx = 1'b1;
        repeat (ncyc) @(negedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] part;
        part = 8'hC3;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("rst_d_out",     {24'd0, d_out},      32'h0);
        check("rst_rx_done",   {31'd0, rx_done},    32'h0);
        check("rst_frame_err", {31'd0, frame_err},  32'h0);
        check("rst_state",     {30'd0, dut.r_state}, {30'd0, c_ST_IDLE});
        reset = 1'b0;
        settle(20);

        // Single good frame
        send_frame(8'hF0, 1'b1);
        settle(20);
        check("f0_done_cnt",    done_cnt, 1);
        check("f0_d_out",       {24'd0, d_out}, 32'hF0);
        check("f0_err_cnt",     err_cnt, 0);
        check("f0_pulse_width", wide_cnt, 0);

        // Back-to-back frames, no idle gap
        rx_q.delete();
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        settle(20);
        check("b2b_count",   rx_q.size(), 2);
        check("b2b_first",   {24'd0, rx_q[0]}, 32'h55);
        check("b2b_second",  {24'd0, rx_q[1]}, 32'hAA);
        check("b2b_spacing", done_last - done_prev, 640);
        check("b2b_err_cnt", err_cnt, 0);

        // Short low glitch (12 clk) is rejected
        hold(1'b0, 12);
        settle(100);
        check("glitch_done_cnt", done_cnt, 3);
        check("glitch_err_cnt",  err_cnt, 0);
        check("glitch_state",    {30'd0, dut.r_state}, {30'd0, c_ST_IDLE});
        send_frame(8'h3C, 1'b1);
        settle(20);
        check("post_glitch_d_out", {24'd0, d_out}, 32'h3C);
        check("post_glitch_cnt",   done_cnt, 4);

        // Framing error keeps the previous byte
        send_frame(8'h11, 1'b1);
        settle(20);
        check("pre_ferr_d_out", {24'd0, d_out}, 32'h11);
        send_frame(8'hA5, 1'b0);
        settle(100);
        check("ferr_err_cnt",  err_cnt, 1);
        check("ferr_done_cnt", done_cnt, 5);
        check("ferr_d_out",    {24'd0, d_out}, 32'h11);
        check("ferr_width",    wide_cnt, 0);

        // Reset in the middle of data bit 4
        hold(1'b0, c_BIT);
        for (int i = 0; i < 4; i++) hold(part[i], c_BIT);
        hold(part[4], 32);
        reset = 1'b1;
        #1;
        check("midrst_d_out",   {24'd0, d_out},   32'h0);
        check("midrst_rx_done", {31'd0, rx_done}, 32'h0);
        hold(1'b1, 10);
        reset = 1'b0;
        settle(100);
        check("midrst_done_cnt", done_cnt, 5);
        check("midrst_err_cnt",  err_cnt, 1);
        send_frame(8'h7E, 1'b1);
        settle(20);
        check("post_rst_d_out",    {24'd0, d_out}, 32'h7E);
        check("post_rst_done_cnt", done_cnt, 6);

        // Transmitter-style stream, back to back
        rx_q.delete();
        send_frame(8'hF0, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        settle(20);
        check("loop_count",   rx_q.size(), 3);
        check("loop_byte0",   {24'd0, rx_q[0]}, 32'hF0);
        check("loop_byte1",   {24'd0, rx_q[1]}, 32'h55);
        check("loop_byte2",   {24'd0, rx_q[2]}, 32'hAA);
        check("loop_err_cnt", err_cnt, 1);
        check("loop_width",   wide_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_rx
`default_nettype wire
